// File: rtl/ins_encoder_pkg.sv
// Shared constants for the instruction encoder: immediate types, error codes
// and the instruction bit positions each immediate type occupies.
package ins_encoder_pkg;

    localparam logic [2:0] IMM_R = 3'd0;
    localparam logic [2:0] IMM_I = 3'd1;
    localparam logic [2:0] IMM_S = 3'd2;
    localparam logic [2:0] IMM_B = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;
    localparam logic [2:0] IMM_J = 3'd5;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_RANGE    = 2'd1;
    localparam logic [1:0] ERR_ALIGN    = 2'd2;
    localparam logic [1:0] ERR_CONFLICT = 2'd3;

    // Bits of the instruction word owned by each immediate format.
    localparam logic [31:0] MASK_R = 32'h0000_0000;
    localparam logic [31:0] MASK_I = 32'hFFF0_0000;
    localparam logic [31:0] MASK_S = 32'hFE00_0F80;
    localparam logic [31:0] MASK_B = 32'hFE00_0F80;
    localparam logic [31:0] MASK_U = 32'hFFFF_F000;
    localparam logic [31:0] MASK_J = 32'hFFFF_F000;

    function automatic logic [31:0] imm_mask(input logic [2:0] op);
        case (op)
            IMM_I:   return MASK_I;
            IMM_S:   return MASK_S;
            IMM_B:   return MASK_B;
            IMM_U:   return MASK_U;
            IMM_J:   return MASK_J;
            default: return MASK_R;
        endcase
    endfunction

endpackage

// File: rtl/ins_imm_pack.sv
// Combinational immediate scatter and legality check for one instruction word.
module ins_imm_pack
    import ins_encoder_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] base,
    input  logic [31:0] imm,
    output logic [31:0] ins,
    output logic        ok,
    output logic [1:0]  code
);

    // True when imm is the sign extension of its low nbits bits.
    function automatic logic fits_signed(input logic [31:0] val, input int nbits);
        logic signed [31:0] sval;
        logic signed [31:0] top;
        sval = signed'(val);
        top  = sval >>> (nbits - 1);
        return (top == 32'sd0) || (top == -32'sd1);
    endfunction

    logic [31:0] field;
    logic        op_legal;
    logic        align_ok;
    logic        range_ok;

    always_comb begin
        field    = 32'h0;
        op_legal = 1'b1;
        align_ok = 1'b1;
        range_ok = 1'b1;
        case (op)
            IMM_R: ;
            IMM_I: begin
                field[31:20] = imm[11:0];
                range_ok     = fits_signed(imm, 12);
            end
            IMM_S: begin
                field[31:25] = imm[11:5];
                field[11:7]  = imm[4:0];
                range_ok     = fits_signed(imm, 12);
            end
            IMM_B: begin
                field[31]    = imm[12];
                field[30:25] = imm[10:5];
                field[11:8]  = imm[4:1];
                field[7]     = imm[11];
                align_ok     = ~imm[0];
                range_ok     = fits_signed(imm, 13);
            end
            IMM_U: begin
                field[31:12] = imm[31:12];
                align_ok     = (imm[11:0] == 12'h0);
            end
            IMM_J: begin
                field[31]    = imm[20];
                field[30:21] = imm[10:1];
                field[20]    = imm[11];
                field[19:12] = imm[19:12];
                align_ok     = ~imm[0];
                range_ok     = fits_signed(imm, 21);
            end
            default: op_legal = 1'b0;
        endcase
    end

    always_comb begin
        ins  = base | field;
        ok   = 1'b0;
        code = ERR_NONE;
        if (!op_legal || ((base & imm_mask(op)) != 32'h0)) begin
            code = ERR_CONFLICT;
        end else if (!align_ok) begin
            code = ERR_ALIGN;
        end else if (!range_ok) begin
            code = ERR_RANGE;
        end else begin
            ok = 1'b1;
        end
    end

endmodule

// File: rtl/ins_encoder.sv
// Instruction encoder: packs immediates into base words and streams legal
// words with sequential word addresses to the instruction-memory loader.
module ins_encoder
    import ins_encoder_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int CNT_W      = 8,
    parameter int START_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [31:0]       in_base,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_ins,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W-1:0] err_addr,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  wr_cnt
);

    localparam logic [ADDR_W-1:0] START = ADDR_W'(START_ADDR);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    logic [31:0]       pack_ins_p0;
    logic              pack_ok_p0;
    logic [1:0]        pack_code_p0;
    logic              accept;
    logic              handoff;

    logic              vld_p1;
    logic [31:0]       ins_p1;
    logic [ADDR_W-1:0] addr_p1;
    logic [ADDR_W-1:0] next_addr;

    ins_imm_pack u_pack (
        .op   (in_op),
        .base (in_base),
        .imm  (in_imm),
        .ins  (pack_ins_p0),
        .ok   (pack_ok_p0),
        .code (pack_code_p0)
    );

    assign in_ready = !flush && (!vld_p1 || out_ready);
    assign accept   = in_valid && in_ready;
    assign handoff  = vld_p1 && out_ready;

    // Stage p0 -> p1: output register and address/error bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1    <= 1'b0;
            ins_p1    <= 32'h0;
            addr_p1   <= START;
            next_addr <= START;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
            err_addr  <= '0;
            err_cnt   <= '0;
            wr_cnt    <= '0;
        end else if (flush) begin
            vld_p1    <= 1'b0;
            ins_p1    <= 32'h0;
            addr_p1   <= START;
            next_addr <= START;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
            err_addr  <= '0;
            err_cnt   <= '0;
            wr_cnt    <= '0;
        end else begin
            if (accept && pack_ok_p0) begin
                vld_p1    <= 1'b1;
                ins_p1    <= pack_ins_p0;
                addr_p1   <= next_addr;
                next_addr <= next_addr + 1'b1;
            end else if (handoff) begin
                vld_p1 <= 1'b0;
            end
            if (accept && !pack_ok_p0) begin
                err      <= 1'b1;
                err_code <= pack_code_p0;
                err_addr <= next_addr;
                err_cnt  <= sat_inc(err_cnt);
            end
            if (handoff) begin
                wr_cnt <= sat_inc(wr_cnt);
            end
        end
    end

    assign out_valid = vld_p1;
    assign out_ins   = ins_p1;
    assign out_addr  = addr_p1;

endmodule

// File: tb/tb_ins_encoder.sv
// Directed-vector bench for ins_encoder with hand-computed expected words.
module tb_ins_encoder;

    localparam int ADDR_W = 10;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_op;
    logic [31:0]       in_base;
    logic [31:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_ins;
    logic [ADDR_W-1:0] out_addr;
    logic              err;
    logic [1:0]        err_code;
    logic [ADDR_W-1:0] err_addr;
    logic [CNT_W-1:0]  err_cnt;
    logic [CNT_W-1:0]  wr_cnt;

    int n_checks = 0;
    int n_errors = 0;

    ins_encoder #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .START_ADDR(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_base   (in_base),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ins   (out_ins),
        .out_addr  (out_addr),
        .err       (err),
        .err_code  (err_code),
        .err_addr  (err_addr),
        .err_cnt   (err_cnt),
        .wr_cnt    (wr_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] base, input logic [31:0] imm);
        in_valid = 1'b1;
        in_op    = op;
        in_base  = base;
        in_imm   = imm;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 3'd0;
        in_base   = 32'h0;
        in_imm    = 32'h0;
        out_ready = 1'b1;
        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_ins",   out_ins,        32'h0);
        chk("rst_out_addr",  32'(out_addr),  32'd0);
        chk("rst_err",       32'(err),       32'd0);
        chk("rst_err_cnt",   32'(err_cnt),   32'd0);
        chk("rst_wr_cnt",    32'(wr_cnt),    32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // addi x1,x0,-1
        drive(3'd1, 32'h0000_0093, 32'hFFFF_FFFF);
        #1 chk("addi_in_ready", 32'(in_ready), 32'd1);
        tick; in_valid = 1'b0;
        chk("addi_valid", 32'(out_valid), 32'd1);
        chk("addi_ins",   out_ins,        32'hFFF0_0093);
        chk("addi_addr",  32'(out_addr),  32'd0);
        tick;
        chk("addi_done_valid", 32'(out_valid), 32'd0);
        chk("addi_wr_cnt",     32'(wr_cnt),    32'd1);

        flush = 1'b1;
        tick; flush = 1'b0;
        chk("flush0_wr_cnt", 32'(wr_cnt), 32'd0);

        // beq x0,x0,-4 then jal x1,8 back-to-back
        drive(3'd3, 32'h0000_0063, 32'hFFFF_FFFC);
        tick;
        drive(3'd5, 32'h0000_00EF, 32'h0000_0008);
        #1;
        chk("beq_ins",      out_ins,        32'hFE00_0EE3);
        chk("beq_addr",     32'(out_addr),  32'd0);
        chk("beq_in_ready", 32'(in_ready),  32'd1);
        tick; in_valid = 1'b0;
        chk("jal_ins",    out_ins,       32'h0080_00EF);
        chk("jal_addr",   32'(out_addr), 32'd1);
        chk("jal_wr_cnt", 32'(wr_cnt),   32'd1);
        tick;
        chk("bj_wr_cnt", 32'(wr_cnt),    32'd2);
        chk("bj_valid",  32'(out_valid), 32'd0);

        // lui x5,0x12345 then a misaligned U immediate
        drive(3'd4, 32'h0000_02B7, 32'h1234_5000);
        tick;
        chk("lui_ins",  out_ins,       32'h1234_52B7);
        chk("lui_addr", 32'(out_addr), 32'd2);
        drive(3'd4, 32'h0000_02B7, 32'h1234_5001);
        tick; in_valid = 1'b0;
        chk("lui_bad_err",      32'(err),       32'd1);
        chk("lui_bad_code",     32'(err_code),  32'd2);
        chk("lui_bad_cnt",      32'(err_cnt),   32'd1);
        chk("lui_bad_err_addr", 32'(err_addr),  32'd3);
        chk("lui_bad_valid",    32'(out_valid), 32'd0);
        chk("lui_bad_wr_cnt",   32'(wr_cnt),    32'd3);
        drive(3'd1, 32'h0000_0093, 32'h0000_0005);
        tick;
        chk("reuse_addr", 32'(out_addr), 32'd3);
        chk("reuse_ins",  out_ins,       32'h0050_0093);

        // Range / conflict / illegal op
        drive(3'd1, 32'h0000_0093, 32'h0000_0800);
        tick;
        chk("i_range_code", 32'(err_code), 32'd1);
        chk("i_range_wr",   32'(wr_cnt),   32'd4);
        drive(3'd1, 32'h0010_0093, 32'h0000_0000);
        tick;
        chk("i_conflict_code", 32'(err_code), 32'd3);
        drive(3'd7, 32'h0000_0000, 32'h0000_0000);
        tick;
        chk("op7_code",     32'(err_code), 32'd3);
        chk("op7_err_cnt",  32'(err_cnt),  32'd4);
        chk("op7_err_addr", 32'(err_addr), 32'd4);
        drive(3'd3, 32'h0000_0063, 32'h0000_1000);
        tick; in_valid = 1'b0;
        chk("b_range_code", 32'(err_code), 32'd1);
        chk("b_range_cnt",  32'(err_cnt),  32'd5);

        // Backpressure
        out_ready = 1'b0;
        drive(3'd1, 32'h0000_0093, 32'h0000_07FF);
        tick;
        drive(3'd1, 32'h0000_0093, 32'h0000_0001);
        for (int i = 0; i < 3; i++) begin
            chk("bp_in_ready", 32'(in_ready),  32'd0);
            chk("bp_valid",    32'(out_valid), 32'd1);
            chk("bp_ins",      out_ins,        32'h7FF0_0093);
            chk("bp_addr",     32'(out_addr),  32'd4);
            tick;
        end
        chk("bp_wr_hold", 32'(wr_cnt), 32'd4);
        out_ready = 1'b1;
        #1 chk("bp_release_ready", 32'(in_ready), 32'd1);
        tick; in_valid = 1'b0;
        chk("bp_next_ins",  out_ins,       32'h0010_0093);
        chk("bp_next_addr", 32'(out_addr), 32'd5);
        chk("bp_wr_cnt",    32'(wr_cnt),   32'd5);

        // Flush with a pending word and a sticky error
        out_ready = 1'b0;
        flush = 1'b1;
        #1 chk("flush_in_ready", 32'(in_ready), 32'd0);
        tick; flush = 1'b0;
        chk("flush_valid",   32'(out_valid), 32'd0);
        chk("flush_err",     32'(err),       32'd0);
        chk("flush_code",    32'(err_code),  32'd0);
        chk("flush_err_cnt", 32'(err_cnt),   32'd0);
        chk("flush_wr_cnt",  32'(wr_cnt),    32'd0);
        out_ready = 1'b1;
        drive(3'd1, 32'h0000_0093, 32'hFFFF_FFFF);
        tick; in_valid = 1'b0;
        chk("post_flush_addr", 32'(out_addr), 32'd0);
        chk("post_flush_ins",  out_ins,       32'hFFF0_0093);

        // Asynchronous reset with a word pending
        drive(3'd1, 32'h0000_0093, 32'h0000_0002);
        out_ready = 1'b0;
        tick; in_valid = 1'b0;
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid",  32'(out_valid), 32'd0);
        chk("arst_ins",    out_ins,        32'h0);
        chk("arst_addr",   32'(out_addr),  32'd0);
        chk("arst_wr_cnt", 32'(wr_cnt),    32'd0);
        tick; rst = 1'b0;
        out_ready = 1'b1;
        drive(3'd2, 32'h0000_2023, 32'hFFFF_FFF8);
        tick; in_valid = 1'b0;
        chk("post_rst_s_ins",  out_ins,       32'hFE00_2C23);
        chk("post_rst_s_addr", 32'(out_addr), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
